machine_timer: RTL and testbench

//  Memory-mapped RISC-V machine timer (mtime/mtimecmp). It is the source of the csr_file timer_irq input.

---
 rtl/mtimer_pkg.sv | 37 +++
 rtl/mtimer_prescaler.sv | 28 ++
 rtl/machine_timer.sv | 142 ++++++++++++++
 tb/tb_machine_timer.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mtimer_pkg.sv
// Shared offsets, reset constants and register decode for the machine timer.
// MTIMER_SWI_EN adds the msip register at offset 0x10.
package mtimer_pkg;

   localparam logic [4:0]  OFF_MTIME_LO   = 5'h00;
   localparam logic [4:0]  OFF_MTIME_HI   = 5'h04;
   localparam logic [4:0]  OFF_CMP_LO     = 5'h08;
   localparam logic [4:0]  OFF_CMP_HI     = 5'h0C;
   localparam logic [4:0]  OFF_MSIP       = 5'h10;
   localparam logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      MTIME_LO,
      MTIME_HI,
      CMP_LO,
      CMP_HI,
      MSIP,
      UNMAPPED
   } mtimer_reg_e;

   // Word index only; byte-lane bits of the offset are ignored.
   function automatic mtimer_reg_e decode_reg(input logic [2:0] word);
      mtimer_reg_e sel;
      case ({word, 2'b00})
         OFF_MTIME_LO: sel = MTIME_LO;
         OFF_MTIME_HI: sel = MTIME_HI;
         OFF_CMP_LO:   sel = CMP_LO;
         OFF_CMP_HI:   sel = CMP_HI;
`ifdef MTIMER_SWI_EN
         OFF_MSIP:     sel = MSIP;
`endif
         default:      sel = UNMAPPED;
      endcase
      return sel;
   endfunction

endpackage

// File: rtl/mtimer_prescaler.sv
// Divides clk_i down to a one-cycle tick every PRESCALE cycles.
module mtimer_prescaler #(
   parameter int unsigned PRESCALE = 1
) (
   input  logic clk_i,
   input  logic reset_i,
   output logic tick_o
);

   localparam logic [15:0] LAST = 16'(PRESCALE - 1);

   logic [15:0] count_q, count_d;

   assign tick_o = (count_q == LAST);

   always_comb begin
      count_d = tick_o ? 16'd0 : count_q + 16'd1;
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/machine_timer.sv
// Memory-mapped RISC-V mtime/mtimecmp with a level timer interrupt.
// Define MTIMER_SWI_EN to add the msip register and the soft_irq_o output.
module machine_timer
   import mtimer_pkg::*;
#(
   parameter int unsigned PRESCALE = 1
) (
   input  logic        clk_i,
   input  logic        reset_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic        req_we_i,
   input  logic [4:0]  req_addr_i,
   input  logic [31:0] req_wdata_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_rdata_o,
   output logic        rsp_err_o,
`ifdef MTIMER_SWI_EN
   output logic        soft_irq_o,
`endif
   output logic        timer_irq_o
);

   logic        tick;
   logic        accept;
   logic        wr;
   mtimer_reg_e sel;
   logic [31:0] rd_data;
   logic        unused_addr;

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] mtimecmp_q, mtimecmp_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [31:0] rsp_rdata_q, rsp_rdata_d;
   logic        rsp_err_q, rsp_err_d;
   logic        timer_irq_q;
`ifdef MTIMER_SWI_EN
   logic        msip_q, msip_d;
   logic        soft_irq_q;
`endif

   mtimer_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .tick_o  (tick)
   );

   assign unused_addr = ^req_addr_i[1:0];
   assign req_ready_o = ~rsp_valid_q | rsp_ready_i;
   assign accept      = req_valid_i & req_ready_o;
   assign wr          = accept & req_we_i;
   assign sel         = decode_reg(req_addr_i[4:2]);

   // A write to either mtime half suppresses that cycle's increment entirely.
   always_comb begin
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      mtimecmp_d = mtimecmp_q;
`ifdef MTIMER_SWI_EN
      msip_d     = msip_q;
`endif
      if (wr) begin
         case (sel)
            MTIME_LO: mtime_d    = {mtime_q[63:32], req_wdata_i};
            MTIME_HI: mtime_d    = {req_wdata_i, mtime_q[31:0]};
            CMP_LO:   mtimecmp_d = {mtimecmp_q[63:32], req_wdata_i};
            CMP_HI:   mtimecmp_d = {req_wdata_i, mtimecmp_q[31:0]};
`ifdef MTIMER_SWI_EN
            MSIP:     msip_d     = req_wdata_i[0];
`endif
            default:  ;
         endcase
      end
   end

   always_comb begin
      rd_data = '0;
      case (sel)
         MTIME_LO: rd_data = mtime_q[31:0];
         MTIME_HI: rd_data = mtime_q[63:32];
         CMP_LO:   rd_data = mtimecmp_q[31:0];
         CMP_HI:   rd_data = mtimecmp_q[63:32];
`ifdef MTIMER_SWI_EN
         MSIP:     rd_data = {31'd0, msip_q};
`endif
         default:  ;
      endcase
   end

   always_comb begin
      rsp_valid_d = rsp_valid_q;
      rsp_rdata_d = rsp_rdata_q;
      rsp_err_d   = rsp_err_q;
      if (accept) begin
         rsp_valid_d = 1'b1;
         rsp_rdata_d = req_we_i ? 32'd0 : rd_data;
         rsp_err_d   = (sel == UNMAPPED);
      end else if (rsp_ready_i) begin
         rsp_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         mtime_q     <= '0;
         mtimecmp_q  <= MTIMECMP_RESET;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         rsp_err_q   <= 1'b0;
         timer_irq_q <= 1'b0;
      end else begin
         mtime_q     <= mtime_d;
         mtimecmp_q  <= mtimecmp_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         rsp_err_q   <= rsp_err_d;
         timer_irq_q <= (mtime_q >= mtimecmp_q);
      end
   end

`ifdef MTIMER_SWI_EN
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         msip_q     <= 1'b0;
         soft_irq_q <= 1'b0;
      end else begin
         msip_q     <= msip_d;
         soft_irq_q <= msip_q;
      end
   end

   assign soft_irq_o = soft_irq_q;
`endif

   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign timer_irq_o = timer_irq_q;

endmodule

// File: tb/tb_machine_timer.sv
// Directed bench for machine_timer: vector table on a PRESCALE=1 instance plus
// hand sequences for backpressure, reset, PRESCALE=4 and (with MTIMER_SWI_EN) msip.
module tb_machine_timer;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_we, rsp_ready;
   logic [4:0]  req_addr;
   logic [31:0] req_wdata;
   logic        req_ready, rsp_valid, rsp_err, timer_irq;
   logic [31:0] rsp_rdata;
   logic        soft_irq;

   logic        p4_req_valid, p4_req_we, p4_rsp_ready;
   logic [4:0]  p4_req_addr;
   logic [31:0] p4_req_wdata;
   logic        p4_req_ready, p4_rsp_valid, p4_rsp_err, p4_timer_irq;
   logic [31:0] p4_rsp_rdata;
   logic        p4_soft_irq;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   machine_timer #(.PRESCALE(1)) dut (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .req_we_i    (req_we),
      .req_addr_i  (req_addr),
      .req_wdata_i (req_wdata),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_rdata_o (rsp_rdata),
      .rsp_err_o   (rsp_err),
`ifdef MTIMER_SWI_EN
      .soft_irq_o  (soft_irq),
`endif
      .timer_irq_o (timer_irq)
   );

   machine_timer #(.PRESCALE(4)) dut_p4 (
      .clk_i       (clk),
      .reset_i     (reset),
      .req_valid_i (p4_req_valid),
      .req_ready_o (p4_req_ready),
      .req_we_i    (p4_req_we),
      .req_addr_i  (p4_req_addr),
      .req_wdata_i (p4_req_wdata),
      .rsp_valid_o (p4_rsp_valid),
      .rsp_ready_i (p4_rsp_ready),
      .rsp_rdata_o (p4_rsp_rdata),
      .rsp_err_o   (p4_rsp_err),
`ifdef MTIMER_SWI_EN
      .soft_irq_o  (p4_soft_irq),
`endif
      .timer_irq_o (p4_timer_irq)
   );

`ifndef MTIMER_SWI_EN
   assign soft_irq    = 1'b0;
   assign p4_soft_irq = 1'b0;
`endif

   typedef struct {
      int          idle;
      bit          req;
      bit          we;
      logic [4:0]  addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      bit          exp_err;
      bit          exp_irq;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(input int idle, input bit req, input bit we, input logic [4:0] addr,
                               input logic [31:0] wdata, input logic [31:0] er, input bit ee,
                               input bit ei);
      vec_t v;
      v.idle = idle; v.req = req; v.we = we; v.addr = addr; v.wdata = wdata;
      v.exp_rdata = er; v.exp_err = ee; v.exp_irq = ei;
      vecs.push_back(v);
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic op(input bit we, input logic [4:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err, output logic vld);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      rdata = rsp_rdata; err = rsp_err; vld = rsp_valid;
   endtask

   task automatic p4_op(input bit we, input logic [4:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic vld);
      p4_req_valid = 1'b1; p4_req_we = we; p4_req_addr = addr; p4_req_wdata = wdata;
      @(posedge clk);
      @(negedge clk);
      p4_req_valid = 1'b0;
      rdata = p4_rsp_rdata; vld = p4_rsp_valid;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic        er, vl;
      int          exp_p4[5];

      reset = 1'b1;
      req_valid = 0; req_we = 0; req_addr = '0; req_wdata = '0; rsp_ready = 1;
      p4_req_valid = 0; p4_req_we = 0; p4_req_addr = '0; p4_req_wdata = '0; p4_rsp_ready = 1;

      // mtime after posedge k (counting from reset release) is k; a read accepted at k returns k-1.
      add(10, 1, 0, 5'h00, 0,            32'd10,       0, 0);
      add(0,  1, 0, 5'h04, 0,            32'd0,        0, 0);
      add(0,  1, 0, 5'h08, 0,            32'hFFFFFFFF, 0, 0);
      add(0,  1, 0, 5'h0C, 0,            32'hFFFFFFFF, 0, 0);
      add(0,  1, 1, 5'h0C, 0,            32'd0,        0, 0);
      add(0,  1, 1, 5'h08, 32'd40,       32'd0,        0, 0);
      add(24, 0, 0, 5'h00, 0,            32'd0,        0, 0);
      add(1,  0, 0, 5'h00, 0,            32'd0,        0, 1);
      add(0,  1, 0, 5'h00, 0,            32'd41,       0, 1);
      add(0,  1, 1, 5'h08, 32'hFFFFFFFF, 32'd0,        0, 1);
      add(1,  0, 0, 5'h00, 0,            32'd0,        0, 0);
      add(0,  1, 1, 5'h00, 32'hFFFFFFFE, 32'd0,        0, 0);
      add(0,  1, 1, 5'h04, 32'd0,        32'd0,        0, 0);
      add(2,  1, 0, 5'h00, 0,            32'd0,        0, 1);
      add(0,  1, 0, 5'h04, 0,            32'd1,        0, 1);
      add(0,  1, 1, 5'h0C, 32'hFFFFFFFF, 32'd0,        0, 1);
      add(0,  1, 1, 5'h08, 32'd5,        32'd0,        0, 0);
      add(0,  1, 1, 5'h0C, 32'd0,        32'd0,        0, 0);
      add(0,  1, 1, 5'h04, 32'hFFFFFFFF, 32'd0,        0, 1);
      add(0,  1, 1, 5'h00, 32'hFFFFFFFF, 32'd0,        0, 1);
      add(1,  0, 0, 5'h00, 0,            32'd0,        0, 1);
      add(1,  0, 0, 5'h00, 0,            32'd0,        0, 0);
      add(0,  1, 0, 5'h00, 0,            32'd1,        0, 0);
      add(0,  1, 0, 5'h14, 0,            32'd0,        1, 0);
      add(0,  1, 1, 5'h18, 32'd123,      32'd0,        1, 0);
      add(0,  1, 0, 5'h1C, 0,            32'd0,        1, 0);
`ifdef MTIMER_SWI_EN
      add(0,  1, 0, 5'h10, 0,            32'd0,        0, 1);
`else
      add(0,  1, 0, 5'h10, 0,            32'd0,        1, 1);
`endif
      add(0,  1, 0, 5'h0B, 0,            32'd5,        0, 1);

      repeat (3) @(negedge clk);
      reset = 1'b0;

      chk("reset rsp_valid", rsp_valid, 0);
      chk("reset rsp_rdata", rsp_rdata, 0);
      chk("reset rsp_err", rsp_err, 0);
      chk("reset timer_irq", timer_irq, 0);
      chk("reset req_ready", req_ready, 1);
      chk("reset soft_irq", soft_irq, 0);

      foreach (vecs[i]) begin
         repeat (vecs[i].idle) @(negedge clk);
         if (vecs[i].req) begin
            op(vecs[i].we, vecs[i].addr, vecs[i].wdata, rd, er, vl);
            chk($sformatf("v%0d rsp_valid", i), vl, 1);
            chk($sformatf("v%0d rdata", i), rd, vecs[i].exp_rdata);
            chk($sformatf("v%0d err", i), er, vecs[i].exp_err);
         end
         chk($sformatf("v%0d timer_irq", i), timer_irq, vecs[i].exp_irq);
      end

      // Backpressure: response for 0x08 held three cycles; a queued 0x14 read must wait.
      @(negedge clk);
      rsp_ready = 0;
      req_valid = 1; req_we = 0; req_addr = 5'h08;
      @(posedge clk);
      @(negedge clk);
      req_addr = 5'h14;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("stall%0d rsp_valid", k), rsp_valid, 1);
         chk($sformatf("stall%0d rdata", k), rsp_rdata, 32'd5);
         chk($sformatf("stall%0d err", k), rsp_err, 0);
         chk($sformatf("stall%0d req_ready", k), req_ready, 0);
         if (k < 3) @(negedge clk);
      end
      rsp_ready = 1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 0;
      chk("queued rsp_valid", rsp_valid, 1);
      chk("queued rdata", rsp_rdata, 0);
      chk("queued err", rsp_err, 1);

      // Reset with a response pending.
      @(negedge clk);
      rsp_ready = 0;
      op(0, 5'h04, 0, rd, er, vl);
      chk("pre-reset rsp_valid", vl, 1);
      reset = 1;
      @(negedge clk);
      reset = 0;
      rsp_ready = 1;
      chk("mid-reset rsp_valid", rsp_valid, 0);
      chk("mid-reset rdata", rsp_rdata, 0);
      chk("mid-reset timer_irq", timer_irq, 0);
      @(negedge clk);
      chk("post-reset rsp_valid", rsp_valid, 0);

      // PRESCALE=4: mtime after posedge k is k/4; a write on a tick edge takes wdata only.
      do_reset();
      exp_p4 = '{1, 1, 1, 1, 2};
      repeat (4) @(negedge clk);
      for (int k = 0; k < 5; k++) begin
         p4_op(0, 5'h00, 0, rd, vl);
         chk($sformatf("p4 read%0d", k), rd, exp_p4[k]);
      end
      repeat (2) @(negedge clk);
      p4_op(1, 5'h00, 32'd100, rd, vl);
      chk("p4 write rsp_valid", vl, 1);
      p4_op(0, 5'h00, 0, rd, vl);
      chk("p4 after tick write", rd, 32'd100);
      repeat (2) @(negedge clk);
      p4_op(0, 5'h00, 0, rd, vl);
      chk("p4 before next tick", rd, 32'd100);
      p4_op(0, 5'h00, 0, rd, vl);
      chk("p4 after next tick", rd, 32'd101);

      op(0, 5'h08, 0, rd, er, vl);
      chk("cmp lo after reset", rd, 32'hFFFFFFFF);
      op(0, 5'h0C, 0, rd, er, vl);
      chk("cmp hi after reset", rd, 32'hFFFFFFFF);

`ifdef MTIMER_SWI_EN
      op(1, 5'h10, 32'd1, rd, er, vl);
      chk("msip wr err", er, 0);
      chk("soft_irq at rsp", soft_irq, 0);
      op(0, 5'h10, 0, rd, er, vl);
      chk("soft_irq after rsp", soft_irq, 1);
      chk("msip readback 1", rd, 32'd1);
      op(1, 5'h10, 32'hFFFFFFFE, rd, er, vl);
      chk("soft_irq still set", soft_irq, 1);
      @(negedge clk);
      chk("soft_irq cleared", soft_irq, 0);
      op(0, 5'h10, 0, rd, er, vl);
      chk("msip readback 0", rd, 32'd0);
      op(1, 5'h10, 32'd3, rd, er, vl);
      op(0, 5'h10, 0, rd, er, vl);
      chk("msip only bit0", rd, 32'd1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
